mem_access: RTL and testbench
=============================

# mem_access

Memory-access pipeline stage directly downstream of the EX/MEM register. Takes the registered ALU result, store data and control bits, runs a load/store transaction on the data bus with a req/gnt/rvalid handshake, formats load data, and registers the write-back payload toward the MEM/WB side. Asserts `stall_o` to freeze the upstream pipeline while a transaction is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 255: bus wait limit in cycles (used only with `MEM_TIMEOUT_EN`); 8-bit counter.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `pc_i`  in  32  instruction PC from EX/MEM.
- `addr_i`  in  32  ALU result: memory address, or write-back value for non-memory ops.
- `store_data_i`  in  32  rs2 value for stores.
- `size_i`  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- `unsigned_i`  in  1  zero-extend loads when 1.
- `MemRead_i`, `MemWrite_i`, `MemtoReg_i`, `RegWrite_i`  in  1 each  control from EX/MEM.
- `rd_i`  in  5  destination register.
- `dbus_req_o`  out  1  request; combinational from state and inputs.
- `dbus_we_o`  out  1  1 = write.
- `dbus_addr_o`  out  32  `{addr_i[31:2],2'b00}`.
- `dbus_be_o`  out  4  byte enables.
- `dbus_wdata_o`  out  32  lane-replicated store data.
- `dbus_gnt_i`, `dbus_rvalid_i`  in  1 each  grant; read-data valid.
- `dbus_rdata_i`  in  32  read data.
- `stall_o`  out  1  upstream must hold its outputs while high.
- `pc_o`  out  32  registered PC.
- `w_data_o`  out  32  registered write-back data.
- `RegWrite_o`  out  1  registered write enable.
- `rd_o`  out  5  registered destination.
- `misalign_o`, `bus_err_o`  out  1 each  one-cycle registered fault pulses.

## Operation
- States: IDLE, REQ (request pending grant), WAIT (read granted, awaiting rvalid).
- Misaligned: half with `addr_i[0]`=1, word with `addr_i[1:0]`≠0. No request, no stall; next edge `misalign_o`=1, `RegWrite_o`=0.
- Non-memory op: registered straight through in one cycle; `w_data_o`=`addr_i`.
- IDLE with aligned mem op: `dbus_req_o`=1 same cycle. gnt and write → complete; gnt and read → WAIT; no gnt → REQ.
- REQ: hold req and all bus fields; on gnt, write → IDLE complete, read → WAIT.
- WAIT: req low; on rvalid, capture, format, → IDLE complete.
- `stall_o` = (aligned mem op in IDLE or state≠IDLE) and not completing this cycle.
- Byte enables: byte `4'b0001<<addr[1:0]`, half `4'b0011<<addr[1:0]`, word `4'b1111`. Write data: byte `{4{sd[7:0]}}`, half `{2{sd[15:0]}}`, word `sd`.
- Load format: select lane by `addr_i[1:0]`, sign-extend unless `unsigned_i`. `w_data_o` = formatted load if `MemtoReg_i`, else `addr_i`.
- While stalled, registered outputs carry a bubble: `RegWrite_o`=0, `rd_o`=0.
- Stores complete with `RegWrite_o`=0 regardless of `RegWrite_i`.
- rvalid/gnt in IDLE with no op pending: ignored.

## Timing
- Reset: state IDLE; `pc_o`, `w_data_o`, `rd_o`=0; `RegWrite_o`, `misalign_o`, `bus_err_o`=0; `dbus_req_o`, `stall_o` drop immediately (async).
- Latency: non-memory, misaligned, write-with-immediate-gnt: 1 edge. Read: result at edge following the rvalid cycle.
- Reset mid-transaction abandons the transaction; no output pulse.

## Configuration
- `MEM_TIMEOUT_EN` defined: 8-bit counter clears on entry to REQ/WAIT, increments each cycle there; at `TIMEOUT_CYCLES` → IDLE, stall released, next edge `bus_err_o`=1, `RegWrite_o`=0. Late rvalid ignored.
- Undefined: no counter, `bus_err_o` tied 0, FSM waits indefinitely.

## Test plan
- ALU op `addr_i`=0x1234, RegWrite=1, rd=5 -> one edge later `w_data_o`=0x1234, `RegWrite_o`=1, `rd_o`=5, `stall_o` never high.
- sb `addr_i`=0x103, sd=0xAABBCCDD, gnt immediate -> `dbus_be_o`=1000, wdata=0xDDDDDDDD, addr=0x100, no stall.
- lb `addr_i`=0x102, gnt after 2 cycles, rvalid 3 cycles later, rdata=0x0080FF00 -> `stall_o` high 5 cycles, `w_data_o`=0xFFFFFF80; lbu gives 0x00000080.
- lw `addr_i`=0x102 -> no req, next edge `misalign_o`=1, `RegWrite_o`=0.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, gnt never -> `bus_err_o` pulse after 4 REQ cycles, stall released.
- Assert `rst_i` in WAIT -> req/stall low immediately, all outputs 0; later rvalid ignored.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage (master) and the data memory (slave):
// request/grant/read-valid handshake plus address, byte enables and data.
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs loads/stores on the data bus, formats load data and
// registers the write-back payload. Optional bus-wait timeout enabled by `define MEM_TIMEOUT_EN.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       store_data_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemtoReg_i,
    input  logic              RegWrite_i,
    input  logic [4:0]        rd_i,
    mem_access_if.master      dbus,
    output logic              stall_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       w_data_o,
    output logic              RegWrite_o,
    output logic [4:0]        rd_o,
    output logic              misalign_o,
    output logic              bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_misalign;
    logic        r_bus_err;

    logic        w_is_mem;
    logic        w_misalign;
    logic        w_mem_ok;
    logic        w_req;
    logic        w_grant;
    logic        w_done;
    logic        w_timeout;
    logic [31:0] w_lane_data;
    logic [31:0] w_load;
    logic [31:0] w_wb_data;
    logic        w_wb_we;

    assign w_is_mem   = MemRead_i | MemWrite_i;
    assign w_misalign = w_is_mem &
                        (((size_i == 2'b01) & addr_i[0]) | (size_i[1] & (addr_i[1:0] != 2'b00)));
    assign w_mem_ok   = w_is_mem & ~w_misalign;

    // Request and stall are gated by reset so they fall the moment reset is asserted.
    assign w_req   = ~rst_i & (((r_state == S_IDLE) & w_mem_ok) | (r_state == S_REQ));
    assign w_grant = w_req & dbus.gnt;
    assign w_done  = (w_grant & MemWrite_i) | ((r_state == S_WAIT) & dbus.rvalid);
    assign stall_o = ~rst_i & (((r_state == S_IDLE) & w_mem_ok) | (r_state != S_IDLE))
                     & ~w_done & ~w_timeout;

    assign dbus.req   = w_req;
    assign dbus.we    = MemWrite_i;
    assign dbus.addr  = {addr_i[31:2], 2'b00};

    always_comb begin
        dbus.be    = 4'b1111;
        dbus.wdata = store_data_i;
        case (size_i)
            2'b00: begin
                dbus.be    = 4'(4'b0001 << addr_i[1:0]);
                dbus.wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                dbus.be    = 4'(4'b0011 << addr_i[1:0]);
                dbus.wdata = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend to the access size.
    assign w_lane_data = dbus.rdata >> {addr_i[1:0], 3'b000};

    always_comb begin
        w_load = w_lane_data;
        case (size_i)
            2'b00: w_load = unsigned_i ? {24'h0, w_lane_data[7:0]}
                                       : {{24{w_lane_data[7]}}, w_lane_data[7:0]};
            2'b01: w_load = unsigned_i ? {16'h0, w_lane_data[15:0]}
                                       : {{16{w_lane_data[15]}}, w_lane_data[15:0]};
            default: ;
        endcase
    end

    assign w_wb_we   = RegWrite_i & ~MemWrite_i;
    assign w_wb_data = (MemtoReg_i & ~MemWrite_i) ? w_load : addr_i;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_cnt;
    logic       w_enter;

    // Counter restarts whenever the FSM moves into REQ or WAIT.
    assign w_enter   = ((r_state == S_IDLE) & w_mem_ok & ~(dbus.gnt & MemWrite_i)) |
                       ((r_state == S_REQ) & dbus.gnt & ~MemWrite_i);
    assign w_timeout = ~rst_i & (r_state != S_IDLE) & (r_cnt == TO_LAST) &
                       ~w_grant & ~w_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= 8'd0;
        end else if (w_enter) begin
            r_cnt <= 8'd0;
        end else if (r_state != S_IDLE) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            pc_o       <= 32'd0;
            w_data_o   <= 32'd0;
            RegWrite_o <= 1'b0;
            rd_o       <= 5'd0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            if (w_timeout) begin
                r_state    <= S_IDLE;
                r_bus_err  <= 1'b1;
                RegWrite_o <= 1'b0;
                rd_o       <= 5'd0;
            end else if (w_done) begin
                r_state    <= S_IDLE;
                pc_o       <= pc_i;
                w_data_o   <= w_wb_data;
                RegWrite_o <= w_wb_we;
                rd_o       <= rd_i;
            end else if (stall_o) begin
                // Bubble toward MEM/WB while the transaction is outstanding.
                RegWrite_o <= 1'b0;
                rd_o       <= 5'd0;
                case (r_state)
                    S_IDLE:  r_state <= w_grant ? S_WAIT : S_REQ;
                    S_REQ:   r_state <= w_grant ? S_WAIT : S_REQ;
                    S_WAIT:  r_state <= S_WAIT;
                    default: r_state <= S_IDLE;
                endcase
            end else if (w_misalign) begin
                r_misalign <= 1'b1;
                pc_o       <= pc_i;
                w_data_o   <= addr_i;
                RegWrite_o <= 1'b0;
                rd_o       <= 5'd0;
            end else begin
                r_state    <= S_IDLE;
                pc_o       <= pc_i;
                w_data_o   <= addr_i;
                RegWrite_o <= RegWrite_i;
                rd_o       <= rd_i;
            end
        end
    end

    assign misalign_o = r_misalign;
    assign bus_err_o  = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: ALU pass-through, stores, loads with
// delayed handshakes, misalignment, bus timeout (or indefinite wait) and reset mid-read.
module tb_mem_access;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i, addr_i, store_data_i;
    logic [1:0]  size_i;
    logic        unsigned_i, MemRead_i, MemWrite_i, MemtoReg_i, RegWrite_i;
    logic [4:0]  rd_i;
    logic        stall_o, RegWrite_o, misalign_o, bus_err_o;
    logic [31:0] pc_o, w_data_o;
    logic [4:0]  rd_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mem_access_if dbus ();

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pc_i         (pc_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .size_i       (size_i),
        .unsigned_i   (unsigned_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .MemtoReg_i   (MemtoReg_i),
        .RegWrite_i   (RegWrite_i),
        .rd_i         (rd_i),
        .dbus         (dbus),
        .stall_o      (stall_o),
        .pc_o         (pc_o),
        .w_data_o     (w_data_o),
        .RegWrite_o   (RegWrite_o),
        .rd_o         (rd_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_op(input logic [31:0] pc, input logic mr, input logic mw,
                          input logic m2r, input logic rw, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [4:0] rd);
        pc_i = pc; MemRead_i = mr; MemWrite_i = mw; MemtoReg_i = m2r; RegWrite_i = rw;
        size_i = sz; unsigned_i = uns; addr_i = addr; store_data_i = sd; rd_i = rd;
    endtask

    task automatic nop;
        set_op(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    // Load with gnt in cycle gnt_cyc and rvalid in cycle rv_cyc (1-based, gnt_cyc < rv_cyc).
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] rdata, input int gnt_cyc,
                            input int rv_cyc, input logic [31:0] exp, input int exp_stall);
        int stalls = 0;
        set_op(32'h80, 1'b1, 1'b0, 1'b1, 1'b1, sz, uns, addr, 32'h0, 5'd7);
        for (int c = 1; c <= rv_cyc; c++) begin
            dbus.gnt    = (c == gnt_cyc);
            dbus.rvalid = (c == rv_cyc);
            dbus.rdata  = (c == rv_cyc) ? rdata : 32'hDEADBEEF;
            #1;
            if (stall_o) stalls++;
            if (c == gnt_cyc) check_eq({tag, " req"}, 32'(dbus.req), 32'd1);
            if (c == rv_cyc) check_eq({tag, " req in wait"}, 32'(dbus.req), 32'd0);
            if (c == 2) check_eq({tag, " bubble we"}, 32'(RegWrite_o), 32'd0);
            tick;
        end
        dbus.gnt = 1'b0; dbus.rvalid = 1'b0;
        nop;
        check_eq({tag, " data"}, w_data_o, exp);
        check_eq({tag, " we"}, 32'(RegWrite_o), 32'd1);
        check_eq({tag, " rd"}, 32'(rd_o), 32'd7);
        check_eq({tag, " stall cycles"}, 32'(stalls), 32'(exp_stall));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        rst_i = 1'b1;
        dbus.gnt = 1'b0; dbus.rvalid = 1'b0; dbus.rdata = 32'h0;
        // Aligned load on the inputs during reset must not raise req or stall.
        set_op(32'h4, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 5'd1);
        tick; tick;
        check_eq("reset req", 32'(dbus.req), 32'd0);
        check_eq("reset stall", 32'(stall_o), 32'd0);
        check_eq("reset pc", pc_o, 32'h0);
        check_eq("reset wdata", w_data_o, 32'h0);
        check_eq("reset outs", {RegWrite_o, misalign_o, bus_err_o, 24'h0, rd_o}, 32'h0);
        nop;
        tick;
        rst_i = 1'b0;

        // ALU pass-through.
        set_op(32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h1234, 32'h0, 5'd5);
        #1;
        check_eq("alu stall", 32'(stall_o), 32'd0);
        check_eq("alu req", 32'(dbus.req), 32'd0);
        tick;
        check_eq("alu wdata", w_data_o, 32'h1234);
        check_eq("alu we", 32'(RegWrite_o), 32'd1);
        check_eq("alu rd", 32'(rd_o), 32'd5);
        check_eq("alu pc", pc_o, 32'h40);

        // sb with immediate grant.
        set_op(32'h44, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'hAABBCCDD, 5'd6);
        dbus.gnt = 1'b1;
        #1;
        check_eq("sb req", 32'(dbus.req), 32'd1);
        check_eq("sb we", 32'(dbus.we), 32'd1);
        check_eq("sb addr", dbus.addr, 32'h100);
        check_eq("sb be", 32'(dbus.be), 32'h8);
        check_eq("sb wdata", dbus.wdata, 32'hDDDDDDDD);
        check_eq("sb stall", 32'(stall_o), 32'd0);
        tick;
        dbus.gnt = 1'b0;
        check_eq("sb regwrite", 32'(RegWrite_o), 32'd0);
        check_eq("sb pc", pc_o, 32'h44);

        // sh with one-cycle grant delay.
        set_op(32'h48, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h102, 32'hAABBCCDD, 5'd0);
        #1;
        check_eq("sh stall", 32'(stall_o), 32'd1);
        check_eq("sh be", 32'(dbus.be), 32'hC);
        tick;
        dbus.gnt = 1'b1;
        #1;
        check_eq("sh req held", 32'(dbus.req), 32'd1);
        check_eq("sh wdata", dbus.wdata, 32'hCCDDCCDD);
        check_eq("sh stall on gnt", 32'(stall_o), 32'd0);
        tick;
        dbus.gnt = 1'b0;
        check_eq("sh regwrite", 32'(RegWrite_o), 32'd0);

        // Loads.
        run_load("lb",  32'h102, 2'b00, 1'b0, 32'h0080FF00, 3, 6, 32'hFFFFFF80, 5);
        run_load("lbu", 32'h102, 2'b00, 1'b1, 32'h0080FF00, 1, 2, 32'h00000080, 1);
        run_load("lh",  32'h202, 2'b01, 1'b0, 32'h80011234, 1, 3, 32'hFFFF8001, 2);
        run_load("lw",  32'h300, 2'b10, 1'b0, 32'h12345678, 2, 3, 32'h12345678, 2);
        run_load("lhu", 32'h400, 2'b01, 1'b1, 32'hAAAAF00D, 1, 2, 32'h0000F00D, 1);

        // Misaligned word and half.
        set_op(32'h50, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 5'd8);
        #1;
        check_eq("lw mis req", 32'(dbus.req), 32'd0);
        check_eq("lw mis stall", 32'(stall_o), 32'd0);
        tick;
        check_eq("lw mis pulse", 32'(misalign_o), 32'd1);
        check_eq("lw mis we", 32'(RegWrite_o), 32'd0);
        set_op(32'h54, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h101, 32'h0, 5'd8);
        tick;
        check_eq("lh mis pulse", 32'(misalign_o), 32'd1);
        nop;
        tick;
        check_eq("mis pulse drop", 32'(misalign_o), 32'd0);

        // Handshake inputs in IDLE with no memory op are ignored.
        set_op(32'h58, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h55, 32'h0, 5'd3);
        dbus.gnt = 1'b1; dbus.rvalid = 1'b1; dbus.rdata = 32'hFFFFFFFF;
        #1;
        check_eq("idle stray req", 32'(dbus.req), 32'd0);
        tick;
        dbus.gnt = 1'b0; dbus.rvalid = 1'b0;
        check_eq("idle stray wdata", w_data_o, 32'h55);

        // Grant never arrives.
        set_op(32'h60, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h500, 32'h0, 5'd4);
        stalls = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (!stall_o) break;
            stalls++;
            tick;
        end
`ifdef MEM_TIMEOUT_EN
        check_eq("timeout stall cycles", 32'(stalls), 32'd4);
        tick;
        check_eq("timeout bus_err", 32'(bus_err_o), 32'd1);
        check_eq("timeout we", 32'(RegWrite_o), 32'd0);
        nop;
        tick;
        check_eq("timeout pulse drop", 32'(bus_err_o), 32'd0);
`else
        check_eq("no-timeout stall held", 32'(stalls), 32'd30);
        check_eq("no-timeout bus_err", 32'(bus_err_o), 32'd0);
        rst_i = 1'b1;
        nop;
        tick;
        rst_i = 1'b0;
`endif

        // Reset while waiting for rvalid.
        set_op(32'h70, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h77, 32'h0, 5'd9);
        tick;
        set_op(32'h74, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h200, 32'h0, 5'd9);
        dbus.gnt = 1'b1;
        tick;
        dbus.gnt = 1'b0;
        #1;
        check_eq("wait req", 32'(dbus.req), 32'd0);
        check_eq("wait stall", 32'(stall_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check_eq("rst stall", 32'(stall_o), 32'd0);
        check_eq("rst req", 32'(dbus.req), 32'd0);
        check_eq("rst pc", pc_o, 32'h0);
        check_eq("rst wdata", w_data_o, 32'h0);
        nop;
        tick;
        rst_i = 1'b0;
        dbus.rvalid = 1'b1; dbus.rdata = 32'hFFFFFFFF;
        tick;
        dbus.rvalid = 1'b0;
        check_eq("late rvalid we", 32'(RegWrite_o), 32'd0);
        check_eq("late rvalid data", w_data_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
